// File: rtl/riscv_run_ctrl_if.sv
// Run-controller bundle: GPIO control, core result words and the controller outputs.
// "slave" is the controller side and "master" is the harness/GPIO side.
interface riscv_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      ctrl_i;
  logic             finished_program_i;
  logic [31:0]      final_value_i;
  logic [31:0]      success_code_i;
  logic             core_rst_o;
  logic             enable_o;
  logic             stop_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_count_o;
  logic             cycle_ovf_o;
  logic             pass_o;
  logic             fail_o;

  modport slave (
    input  ctrl_i, finished_program_i, final_value_i, success_code_i,
    output core_rst_o, enable_o, stop_o, state_o, cycle_count_o, cycle_ovf_o, pass_o, fail_o
  );

  modport master (
    output ctrl_i, finished_program_i, final_value_i, success_code_i,
    input  core_rst_o, enable_o, stop_o, state_o, cycle_count_o, cycle_ovf_o, pass_o, fail_o
  );
endinterface

// File: rtl/riscv_run_ctrl.sv
// Run controller for the riscv32i test harness: edge-detected GPIO start/abort/soft-reset,
// level pause, cycle counting with saturation, optional watchdog, drain and pass/fail report.
// Optional macro RUN_CTRL_SIM_PRINT_EN adds end-of-run console messages (simulation only).
module riscv_run_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DRAIN_CYCLES   = 30,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned RST_HOLD       = 4
) (
  input logic             clk,
  input logic             reset,
  riscv_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPause   = 3'd2,
    StDrain   = 3'd3,
    StDone    = 3'd4,
    StTimeout = 3'd5,
    StAborted = 3'd6
  } state_e;

  localparam int unsigned      HoldW       = $clog2(RST_HOLD + 1);
  localparam logic [HoldW-1:0] HoldInit    = HoldW'(RST_HOLD);
  localparam logic [CNT_W-1:0] DrainLast   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WdogEn      = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             core_rst_q, core_rst_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             match_q, match_d;
  logic [2:0]       pulse;
  logic             unused_ctrl;

  assign unused_ctrl = ^bus.ctrl_i[31:4];

  // State register; reset holds the core in reset for RST_HOLD cycles after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      core_rst_q <= 1'b1;
      hold_q     <= HoldInit;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drain_q    <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      core_rst_q <= core_rst_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      drain_q    <= drain_d;
      match_q    <= match_d;
    end
  end

  // Next state: prioritised events (soft reset > abort > start > timeout > finish > pause).
  always_comb begin
    state_d    = state_q;
    ctrl_d     = bus.ctrl_i[2:0];
    core_rst_d = core_rst_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    drain_d    = drain_q;
    match_d    = match_q;
    pulse      = bus.ctrl_i[2:0] & ~ctrl_q;

    if (core_rst_q) begin
      hold_d = hold_q - HoldW'(1);
      if (hold_q == HoldW'(1)) core_rst_d = 1'b0;
    end

    // The count advances on every edge that leaves RUN or DRAIN, including the exit edge.
    if (state_q == StRun || state_q == StDrain) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end

    if (pulse[2]) begin
      state_d    = StIdle;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      drain_d    = '0;
      match_d    = 1'b0;
      core_rst_d = 1'b1;
      hold_d     = HoldInit;
    end else if (pulse[1] &&
                 (state_q == StRun || state_q == StPause || state_q == StDrain)) begin
      state_d = StAborted;
    end else if (pulse[0] && !core_rst_q &&
                 (state_q == StIdle || state_q == StDone ||
                  state_q == StTimeout || state_q == StAborted)) begin
      state_d = StRun;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      drain_d = '0;
      match_d = 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (WdogEn && cnt_q == TimeoutLast) begin
            state_d = StTimeout;
          end else if (bus.finished_program_i) begin
            state_d = StDrain;
            drain_d = '0;
            match_d = (bus.final_value_i == bus.success_code_i);
          end else if (bus.ctrl_i[3]) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (!bus.ctrl_i[3]) state_d = StRun;
        end
        StDrain: begin
          if (drain_q == DrainLast) state_d = StDone;
          else                      drain_d = drain_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.core_rst_o    = core_rst_q;
    bus.enable_o      = (state_q == StRun || state_q == StDrain) && !core_rst_q;
    bus.stop_o        = (state_q == StDone || state_q == StTimeout || state_q == StAborted);
    bus.state_o       = state_q;
    bus.cycle_count_o = cnt_q;
    bus.cycle_ovf_o   = ovf_q;
    bus.pass_o        = (state_q == StDone) && match_q;
    bus.fail_o        = ((state_q == StDone) && !match_q) || (state_q == StTimeout);
  end

`ifdef RUN_CTRL_SIM_PRINT_EN
  // Announce each entry into DONE or TIMEOUT exactly once.
  always_ff @(posedge clk) begin
    if (!reset && state_d == StDone && state_q != StDone) begin
      if (match_d) $display("cycles=%0d TB FINISH:Test Passed (code 0x%08h)", cnt_d,
                            bus.success_code_i);
      else         $display("cycles=%0d TB FINISH:Test Failed (code 0x%08h)", cnt_d,
                            bus.success_code_i);
    end
    if (!reset && state_d == StTimeout && state_q != StTimeout) begin
      $display("TB FINISH:Timeout cycles=%0d", cnt_d);
    end
  end
`else
  // Default build is silent.
`endif

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: three instances share one stimulus stream
// (u0 default, u1 with a 50-cycle watchdog, u2 with a 4-bit counter for saturation).
module tb_riscv_run_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] ctrl;
  logic        finished;
  logic [31:0] final_value;
  logic [31:0] success_code;

  int n_vec;
  int n_err;

  riscv_run_ctrl_if #(.CNT_W(32)) u_if0 ();
  riscv_run_ctrl_if #(.CNT_W(32)) u_if1 ();
  riscv_run_ctrl_if #(.CNT_W(4))  u_if2 ();

  assign u_if0.ctrl_i = ctrl;
  assign u_if0.finished_program_i = finished;
  assign u_if0.final_value_i = final_value;
  assign u_if0.success_code_i = success_code;
  assign u_if1.ctrl_i = ctrl;
  assign u_if1.finished_program_i = finished;
  assign u_if1.final_value_i = final_value;
  assign u_if1.success_code_i = success_code;
  assign u_if2.ctrl_i = ctrl;
  assign u_if2.finished_program_i = finished;
  assign u_if2.final_value_i = final_value;
  assign u_if2.success_code_i = success_code;

  riscv_run_ctrl #(.CNT_W(32), .DRAIN_CYCLES(30), .TIMEOUT_CYCLES(0), .RST_HOLD(4)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if0.slave)
  );

  riscv_run_ctrl #(.CNT_W(32), .DRAIN_CYCLES(30), .TIMEOUT_CYCLES(50), .RST_HOLD(4)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1.slave)
  );

  riscv_run_ctrl #(.CNT_W(4), .DRAIN_CYCLES(30), .TIMEOUT_CYCLES(0), .RST_HOLD(4)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start-pulse on bit 0 (low for one cycle, then high).
  task automatic start_pulse();
    ctrl = 32'h0;
    tick();
    ctrl = 32'h1;
    tick();
  endtask

  // From the sample right after a start edge (count 0): run, finish at count 99, drain, DONE.
  task automatic run_and_finish(input logic [31:0] fv, input logic exp_pass);
    int n;
    tick_n(99);
    check_eq("run_cnt99", u_if0.cycle_count_o, 64'd99);
    check_eq("run_state", u_if0.state_o, 64'd1);
    finished = 1'b1;
    final_value = fv;
    tick();
    finished = 1'b0;
    check_eq("drain_entry_state", u_if0.state_o, 64'd3);
    check_eq("drain_entry_cnt", u_if0.cycle_count_o, 64'd100);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_if0.state_o != 3'd3) break;
      n++;
      tick();
    end
    check_eq("drain_len", n, 64'd30);
    check_eq("done_state", u_if0.state_o, 64'd4);
    check_eq("done_cnt", u_if0.cycle_count_o, 64'd130);
    check_eq("done_pass", u_if0.pass_o, {63'd0, exp_pass});
    check_eq("done_fail", u_if0.fail_o, {63'd0, !exp_pass});
    check_eq("done_stop", u_if0.stop_o, 64'd1);
    check_eq("done_enable", u_if0.enable_o, 64'd0);
    tick_n(3);
    check_eq("done_cnt_frozen", u_if0.cycle_count_o, 64'd130);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    ctrl = 32'h0;
    finished = 1'b0;
    final_value = 32'h0;
    success_code = 32'hCAFE_0001;

    // Reset values.
    tick_n(2);
    check_eq("rst_state", u_if0.state_o, 64'd0);
    check_eq("rst_core_rst", u_if0.core_rst_o, 64'd1);
    check_eq("rst_enable", u_if0.enable_o, 64'd0);
    check_eq("rst_stop", u_if0.stop_o, 64'd0);
    check_eq("rst_pass_fail", {u_if0.pass_o, u_if0.fail_o}, 64'd0);
    check_eq("rst_cnt", u_if0.cycle_count_o, 64'd0);

    // Core reset released exactly RST_HOLD edges after reset falls.
    reset = 1'b0;
    tick_n(3);
    check_eq("hold_3", u_if0.core_rst_o, 64'd1);
    tick();
    check_eq("hold_4", u_if0.core_rst_o, 64'd0);

    // Start with junk in the ignored upper bits; held high afterwards.
    ctrl = 32'hFFFF_FFF1;
    tick();
    check_eq("start_state", u_if0.state_o, 64'd1);
    check_eq("start_enable", u_if0.enable_o, 64'd1);
    check_eq("start_cnt", u_if0.cycle_count_o, 64'd0);
    tick();
    check_eq("cnt_step", u_if0.cycle_count_o, 64'd1);
    tick_n(98);
    check_eq("cnt_99", u_if0.cycle_count_o, 64'd99);
    finished = 1'b1;
    final_value = 32'hCAFE_0001;
    tick();
    finished = 1'b0;
    check_eq("p1_drain_state", u_if0.state_o, 64'd3);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        if (u_if0.state_o != 3'd3) break;
        n++;
        tick();
      end
      check_eq("p1_drain_len", n, 64'd30);
    end
    check_eq("p1_done_state", u_if0.state_o, 64'd4);
    check_eq("p1_pass", u_if0.pass_o, 64'd1);
    check_eq("p1_fail", u_if0.fail_o, 64'd0);
    check_eq("p1_stop", u_if0.stop_o, 64'd1);
    check_eq("p1_cnt", u_if0.cycle_count_o, 64'd130);
    // Watchdog instance timed out long before finish; 4-bit instance saturated.
    check_eq("wd_state", u_if1.state_o, 64'd5);
    check_eq("wd_fail", u_if1.fail_o, 64'd1);
    check_eq("sat_cnt", u_if2.cycle_count_o, 64'd15);
    check_eq("sat_ovf", u_if2.cycle_ovf_o, 64'd1);

    // Second run, mismatching result; restart clears the sticky overflow.
    start_pulse();
    check_eq("r2_state", u_if0.state_o, 64'd1);
    check_eq("r2_cnt", u_if0.cycle_count_o, 64'd0);
    check_eq("r2_ovf_clr", u_if2.cycle_ovf_o, 64'd0);
    run_and_finish(32'hCAFE_0002, 1'b0);

    // Watchdog: RUN while count is 49, TIMEOUT on the next edge.
    start_pulse();
    check_eq("t_start_cnt", u_if1.cycle_count_o, 64'd0);
    tick_n(49);
    check_eq("t_cnt49", u_if1.cycle_count_o, 64'd49);
    check_eq("t_still_run", u_if1.state_o, 64'd1);
    tick();
    check_eq("t_state", u_if1.state_o, 64'd5);
    check_eq("t_fail", u_if1.fail_o, 64'd1);
    check_eq("t_pass", u_if1.pass_o, 64'd0);
    check_eq("t_stop", u_if1.stop_o, 64'd1);
    start_pulse();
    check_eq("t_restart_state", u_if1.state_o, 64'd1);
    check_eq("t_restart_cnt", u_if1.cycle_count_o, 64'd0);

    // Pause for 20 cycles at count 11; finish during pause is ignored.
    tick_n(10);
    ctrl = 32'h9;
    tick();
    for (int i = 0; i < 20; i++) begin
      check_eq("pause_state", u_if1.state_o, 64'd2);
      check_eq("pause_enable", u_if1.enable_o, 64'd0);
      check_eq("pause_cnt", u_if1.cycle_count_o, 64'd11);
      finished = (i == 5);
      if (i < 19) tick();
    end
    finished = 1'b0;
    ctrl = 32'h1;
    tick();
    check_eq("resume_state", u_if1.state_o, 64'd1);
    check_eq("resume_cnt", u_if1.cycle_count_o, 64'd11);
    tick();
    check_eq("resume_cnt_inc", u_if1.cycle_count_o, 64'd12);

    // Abort and soft reset rise together: soft reset wins.
    ctrl = 32'h7;
    tick();
    check_eq("sr_state", u_if1.state_o, 64'd0);
    check_eq("sr_core_rst", u_if1.core_rst_o, 64'd1);
    check_eq("sr_cnt", u_if1.cycle_count_o, 64'd0);
    ctrl = 32'h6;
    tick();
    ctrl = 32'h7;
    tick();
    check_eq("sr_start_ignored", u_if1.state_o, 64'd0);
    check_eq("sr_hold3", u_if1.core_rst_o, 64'd1);
    tick();
    check_eq("sr_hold4", u_if1.core_rst_o, 64'd1);
    tick();
    check_eq("sr_released", u_if1.core_rst_o, 64'd0);
    check_eq("sr_state_idle", u_if1.state_o, 64'd0);

    // Abort from RUN.
    start_pulse();
    check_eq("ab_run", u_if1.state_o, 64'd1);
    ctrl = 32'h3;
    tick();
    check_eq("ab_state", u_if1.state_o, 64'd6);
    check_eq("ab_stop", u_if1.stop_o, 64'd1);
    check_eq("ab_pass_fail", {u_if1.pass_o, u_if1.fail_o}, 64'd0);
    check_eq("ab_enable", u_if1.enable_o, 64'd0);

    // Async reset mid-run acts without a clock edge.
    start_pulse();
    tick_n(3);
    check_eq("ar_running", u_if1.cycle_count_o, 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_state", u_if1.state_o, 64'd0);
    check_eq("ar_core_rst", u_if1.core_rst_o, 64'd1);
    check_eq("ar_cnt", u_if1.cycle_count_o, 64'd0);
    check_eq("ar_enable", u_if1.enable_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
